// File: rtl/alu_iter.sv
// alu_iter: multi-cycle EX-stage ALU with an iterative shift-add multiplier.
// Define ALU_ITER_EARLY_EXIT_EN to end MUL as soon as the remaining multiplier bits are zero.
module alu_iter #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_in_0,
  input  logic [DATA_W-1:0] alu_in_1,
  output logic              out_valid,
  output logic [DATA_W-1:0] alu_out,
  output logic              zero_flag
);
  typedef enum logic {IDLE, MUL_RUN} state_t;
  localparam logic [3:0] OP_AND = 4'd0, OP_OR = 4'd1, OP_ADD = 4'd2, OP_SLL = 4'd3,
                         OP_SRL = 4'd4, OP_SUB = 4'd6, OP_SLT = 4'd7, OP_MUL = 4'd8;
  state_t              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [DATA_W-1:0]   alu_out_q, alu_out_d, op_res, acc_sum, mplier_sh;
  logic [SHAMT_W-1:0]  cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d, zero_q, zero_d, mul_done;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign alu_out   = alu_out_q;
  assign zero_flag = zero_q;
  always_comb begin
    op_res = '0;
    case (alu_ctrl)
      OP_AND: op_res = alu_in_0 & alu_in_1;
      OP_OR:  op_res = alu_in_0 | alu_in_1;
      OP_ADD: op_res = alu_in_0 + alu_in_1;
      OP_SUB: op_res = alu_in_0 - alu_in_1;
      OP_SLL: op_res = alu_in_0 << alu_in_1[SHAMT_W-1:0];
      OP_SRL: op_res = alu_in_0 >> alu_in_1[SHAMT_W-1:0];
      OP_SLT: op_res = {{(DATA_W-1){1'b0}}, $signed(alu_in_0) < $signed(alu_in_1)};
      default: op_res = '0;
    endcase
  end
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    alu_out_d   = alu_out_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    acc_sum     = acc_q + (mplier_q[0] ? mcand_q : '0);
    mplier_sh   = mplier_q >> 1;
`ifdef ALU_ITER_EARLY_EXIT_EN
    mul_done    = (cnt_q == SHAMT_W'(DATA_W-1)) || (mplier_sh == '0);
`else
    mul_done    = (cnt_q == SHAMT_W'(DATA_W-1));
`endif
    if (state_q == IDLE) begin
      if (in_valid && alu_ctrl == OP_MUL) begin
        state_d  = MUL_RUN;
        acc_d    = '0;
        mcand_d  = alu_in_0;
        mplier_d = alu_in_1;
        cnt_d    = '0;
      end else if (in_valid) begin
        alu_out_d   = op_res;
        zero_d      = (op_res == '0);
        out_valid_d = 1'b1;
      end
    end else begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_sh;
      cnt_d    = cnt_q + SHAMT_W'(1);
      if (mul_done) begin
        state_d     = IDLE;
        alu_out_d   = acc_sum;
        zero_d      = (acc_sum == '0);
        out_valid_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      alu_out_q   <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      alu_out_q   <= alu_out_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed self-checking bench for alu_iter (DATA_W=32).
module tb_alu_iter;
  logic        clk = 1'b0, arst_n = 1'b0, in_valid = 1'b0;
  logic        in_ready, out_valid, zero_flag;
  logic [3:0]  alu_ctrl = 4'd0;
  logic [31:0] alu_in_0 = '0, alu_in_1 = '0, alu_out;
  int checks = 0, failures = 0;
  alu_iter #(.DATA_W(32)) dut (
    .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .alu_in_0(alu_in_0), .alu_in_1(alu_in_1),
    .out_valid(out_valid), .alu_out(alu_out), .zero_flag(zero_flag)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic int mul_lat(input logic [31:0] b);
`ifdef ALU_ITER_EARLY_EXIT_EN
    int hi = 0;
    for (int i = 0; i < 32; i++) if (b[i]) hi = i;
    return hi + 1;
`else
    return 32;
`endif
  endfunction
  task automatic mul_run(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    int n = 0, lows = 0;
    alu_ctrl = 4'd8; alu_in_0 = a; alu_in_1 = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0; alu_in_0 = 32'hDEAD_BEEF; alu_in_1 = 32'h1234_5678; alu_ctrl = 4'd2;
    if (!in_ready) lows++;
    while (n < 40) begin
      step();
      n++;
      if (out_valid) break;
      if (!in_ready) lows++;
    end
    chk({tag, "_lat"}, n, mul_lat(b));
    chk({tag, "_busy"}, lows, mul_lat(b));
    chk({tag, "_res"}, alu_out, exp);
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    step();
    chk({tag, "_pulse"}, {31'd0, out_valid}, 32'd0);
  endtask
  typedef struct { logic [3:0] op; logic [31:0] a, b, exp; } vec_t;
  vec_t vecs[10] = '{
    '{4'd2, 32'hFFFF_FFFF, 32'h1,         32'h0},
    '{4'd6, 32'd5,         32'd7,         32'hFFFF_FFFE},
    '{4'd7, 32'h8000_0000, 32'h1,         32'h1},
    '{4'd4, 32'h8000_0000, 32'h21,        32'h4000_0000},
    '{4'd0, 32'hF0F0,      32'hFF00,      32'hF000},
    '{4'd1, 32'hF0F0,      32'h0F0F,      32'hFFFF},
    '{4'd3, 32'h1,         32'h24,        32'h10},
    '{4'd7, 32'h1,         32'h8000_0000, 32'h0},
    '{4'd5, 32'hFFFF,      32'h1,         32'h0},
    '{4'd15, 32'hFFFF,     32'h1,         32'h0}
  };
  initial begin
    int n, pulses;
    step();
    step();
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out", alu_out, 32'd0);
    chk("rst_zero", {31'd0, zero_flag}, 32'd1);
    arst_n = 1'b1;
    step();
    chk("idle_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1;
    foreach (vecs[i]) begin
      alu_ctrl = vecs[i].op; alu_in_0 = vecs[i].a; alu_in_1 = vecs[i].b;
      step();
      chk($sformatf("op%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("op%0d_res", i), alu_out, vecs[i].exp);
      chk($sformatf("op%0d_zero", i), {31'd0, zero_flag}, {31'd0, vecs[i].exp == 0});
    end
    in_valid = 1'b0;
    step();
    chk("b2b_end_valid", {31'd0, out_valid}, 32'd0);
    mul_run("mul_a", 32'h0001_2345, 32'h10, 32'h0012_3450);
    mul_run("mul_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);
    mul_run("mul_7x3", 32'd7, 32'd3, 32'd21);
    mul_run("mul_7x0", 32'd7, 32'd0, 32'd0);
    chk("mul_7x0_zero", {31'd0, zero_flag}, 32'd1);
    alu_ctrl = 4'd8; alu_in_0 = 32'd3; alu_in_1 = 32'd5; in_valid = 1'b1;
    step();
    alu_ctrl = 4'd2; alu_in_0 = 32'd1; alu_in_1 = 32'd1;
    n = 0; pulses = 0;
    while (n < 40) begin
      step();
      n++;
      if (out_valid) break;
    end
    chk("stall_mul_lat", n, mul_lat(32'd5));
    chk("stall_mul_res", alu_out, 32'd15);
    step();
    chk("stall_add_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_add_res", alu_out, 32'd2);
    in_valid = 1'b0;
    step();
    chk("stall_no_dup", {31'd0, out_valid}, 32'd0);
    alu_ctrl = 4'd8; alu_in_0 = 32'h0001_2345; alu_in_1 = 32'hFFFF_FFFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    chk("abort_busy", {31'd0, in_ready}, 32'd0);
    arst_n = 1'b0;
    step();
    arst_n = 1'b1;
    chk("abort_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out", alu_out, 32'd0);
    chk("abort_zero", {31'd0, zero_flag}, 32'd1);
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    repeat (35) begin
      step();
      if (out_valid) pulses++;
    end
    chk("abort_no_pulse", pulses, 32'd0);
    mul_run("mul_post", 32'd6, 32'd7, 32'd42);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
